// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite memory test master: writes a deterministic pattern over a word range,
// reads it back and compares, for one or more passes. Reports counters and status.
module ahb_lite_mem_tester #(
  parameter int WORD_COUNT = 64,
  parameter int BURST_MODE = 0,
  parameter int PATTERN    = 0,
  parameter int PASSES     = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        START,
  input  logic [31:0] STARTADDR,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HSEL,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] ERRCOUNT,
  output logic [7:0]  CHKCOUNT,
  output logic [31:0] FIRST_ERR_ADDR,
  output logic        S_WRITE,
  output logic        S_CHECK,
  output logic        S_SUCCESS,
  output logic        S_FAILED
);
  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, CHECK, CDRAIN, DONE} state_t;

  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NSEQ   = 2'b10;
  localparam logic [1:0]  TR_SEQ    = 2'b11;
  localparam logic [2:0]  BURST_VAL = (BURST_MODE != 0) ? 3'b011 : 3'b000;
  localparam logic [31:0] WC        = 32'(WORD_COUNT);
  localparam logic [31:0] NPASS     = 32'(PASSES);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d, beat_q, beat_d, pass_q, pass_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [2:0]  hburst_q, hburst_d;
  logic        hsel_q, hsel_d, hwrite_q, hwrite_d;
  // Outstanding data phase: what was accepted and what the read should return
  logic        dp_vld_q, dp_vld_d, dp_wr_q, dp_wr_d;
  logic [31:0] dp_addr_q, dp_addr_d, dp_exp_q, dp_exp_d;
  logic [31:0] err_q, err_d, ferr_q, ferr_d;
  logic [7:0]  chk_q, chk_d;
  logic        succ_q, succ_d, fail_q, fail_d, start_q;
  logic        acc, dcomp, bad;

  // Expected word for an address; odd passes use the inverted pattern
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic odd);
    logic [31:0] v;
    v = (PATTERN != 0) ? (a ^ 32'hA5A5_A5A5) : a;
    return odd ? ~v : v;
  endfunction

  // Beat 0 of every INCR4 group starts the burst; single mode is always NONSEQ
  function automatic logic [1:0] trans_for(input logic [1:0] b);
    return (BURST_MODE != 0 && b != 2'b00) ? TR_SEQ : TR_NSEQ;
  endfunction

  // Next-state, bus pipeline and counter logic
  always_comb begin
    state_d  = state_q;  base_d   = base_q;   beat_d   = beat_q;   pass_d  = pass_q;
    haddr_d  = haddr_q;  htrans_d = htrans_q; hburst_d = hburst_q; hsel_d  = hsel_q;
    hwrite_d = hwrite_q; hwdata_d = hwdata_q;
    dp_vld_d = dp_vld_q; dp_wr_d  = dp_wr_q;  dp_addr_d = dp_addr_q; dp_exp_d = dp_exp_q;
    err_d    = err_q;    ferr_d   = ferr_q;   chk_d    = chk_q;
    succ_d   = succ_q;   fail_d   = fail_q;

    acc   = HREADY && htrans_q[1];
    dcomp = HREADY && dp_vld_q;
    bad   = HRESP || (!dp_wr_q && (HRDATA != dp_exp_q));

    // An accepted address becomes the data phase; write data follows one cycle later
    if (HREADY) begin
      dp_vld_d = acc;
      if (acc) begin
        dp_wr_d   = hwrite_q;
        dp_addr_d = haddr_q;
        dp_exp_d  = pattern(haddr_q, pass_q[0]);
        if (hwrite_q) hwdata_d = pattern(haddr_q, pass_q[0]);
      end
    end

    if (dcomp && bad) begin
      if (err_q == 32'd0) ferr_d = dp_addr_q;
      if (err_q != 32'hFFFF_FFFF) err_d = err_q + 32'd1;
    end

    case (state_q)
      IDLE: if (START) begin
        base_d   = STARTADDR & 32'hFFFF_FFFC;
        err_d    = '0; ferr_d = '0; chk_d = '0; succ_d = 1'b0; fail_d = 1'b0; pass_d = '0;
        haddr_d  = base_d;  htrans_d = TR_NSEQ; hburst_d = BURST_VAL;
        hsel_d   = 1'b1;    hwrite_d = 1'b1;    beat_d   = 32'd1;
        state_d  = WRITE;
      end
      WRITE, CHECK: if (acc) begin
        if (beat_q == WC) begin
          htrans_d = TR_IDLE;
          hsel_d   = 1'b0;
          state_d  = (state_q == WRITE) ? WDRAIN : CDRAIN;
        end else begin
          haddr_d  = base_q + {beat_q[29:0], 2'b00};
          htrans_d = trans_for(beat_q[1:0]);
          beat_d   = beat_q + 32'd1;
        end
      end
      WDRAIN: if (dcomp) begin
        haddr_d = base_q; htrans_d = TR_NSEQ; hsel_d = 1'b1; hwrite_d = 1'b0;
        beat_d  = 32'd1;  state_d  = CHECK;
      end
      CDRAIN: if (dcomp) begin
        chk_d  = chk_q + 8'd1;
        pass_d = pass_q + 32'd1;
        succ_d = (err_d == 32'd0);
        fail_d = (err_d != 32'd0);
        if (NPASS == 32'd0 || (pass_q + 32'd1) < NPASS) begin
          haddr_d = base_q; htrans_d = TR_NSEQ; hsel_d = 1'b1; hwrite_d = 1'b1;
          beat_d  = 32'd1;  state_d  = WRITE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: if (START && !start_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops the bus immediately, even mid-burst
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE; base_q  <= '0; beat_q   <= '0; pass_q   <= '0;
      haddr_q  <= '0;   htrans_q <= TR_IDLE; hburst_q <= '0; hsel_q <= 1'b0;
      hwrite_q <= 1'b0; hwdata_q <= '0;
      dp_vld_q <= 1'b0; dp_wr_q <= 1'b0; dp_addr_q <= '0; dp_exp_q <= '0;
      err_q    <= '0;   ferr_q  <= '0;   chk_q    <= '0;
      succ_q   <= 1'b0; fail_q  <= 1'b0; start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;  base_q   <= base_d;   beat_q   <= beat_d;   pass_q <= pass_d;
      haddr_q  <= haddr_d;  htrans_q <= htrans_d; hburst_q <= hburst_d; hsel_q <= hsel_d;
      hwrite_q <= hwrite_d; hwdata_q <= hwdata_d;
      dp_vld_q <= dp_vld_d; dp_wr_q  <= dp_wr_d;  dp_addr_q <= dp_addr_d; dp_exp_q <= dp_exp_d;
      err_q    <= err_d;    ferr_q   <= ferr_d;   chk_q    <= chk_d;
      succ_q   <= succ_d;   fail_q   <= fail_d;   start_q  <= START;
    end
  end

  assign HADDR          = haddr_q;
  assign HBURST         = hburst_q;
  assign HSEL           = hsel_q;
  assign HSIZE          = 3'b010;
  assign HTRANS         = htrans_q;
  assign HWDATA         = hwdata_q;
  assign HWRITE         = hwrite_q;
  assign ERRCOUNT       = err_q;
  assign CHKCOUNT       = chk_q;
  assign FIRST_ERR_ADDR = ferr_q;
  assign S_WRITE        = (state_q == WRITE);
  assign S_CHECK        = (state_q == CHECK);
  assign S_SUCCESS      = succ_q;
  assign S_FAILED       = fail_q;
endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Bench for ahb_lite_mem_tester: two instances (single/forever/pattern 0 and
// INCR4/2 passes/pattern 1), a randomly stalling slave with fault injection, and a
// scoreboard of expected address/data beats built from the pattern rules.
module tb_ahb_lite_mem_tester;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  tr;
    logic [2:0]  hb;
    logic [31:0] data;
  } beat_t;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int WC = (g == 0) ? 6 : 8;
    localparam int BM = g;
    localparam int PT = g;
    localparam int NP = (g == 0) ? 0 : 2;

    logic        rst_n = 1'b1, start = 1'b0, hready = 1'b1, hresp = 1'b0;
    logic [31:0] saddr = '0, hrdata = '0;
    logic [31:0] haddr, hwdata, errc, ferr;
    logic [2:0]  hburst, hsize;
    logic [1:0]  htrans;
    logic [7:0]  chkc;
    logic        hsel, hwrite, s_w, s_c, s_s, s_f;

    ahb_lite_mem_tester #(.WORD_COUNT(WC), .BURST_MODE(BM), .PATTERN(PT), .PASSES(NP)) dut (
      .HCLK(clk), .HRESETn(rst_n), .START(start), .STARTADDR(saddr),
      .HADDR(haddr), .HBURST(hburst), .HSEL(hsel), .HSIZE(hsize), .HTRANS(htrans),
      .HWDATA(hwdata), .HWRITE(hwrite), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
      .ERRCOUNT(errc), .CHKCOUNT(chkc), .FIRST_ERR_ADDR(ferr),
      .S_WRITE(s_w), .S_CHECK(s_c), .S_SUCCESS(s_s), .S_FAILED(s_f));

    beat_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          fin = 1'b0, flip_en = 1'b0, resp_armed = 1'b0;
    logic [31:0] flip_addr = '0, resp_addr = '0;
    int          nacc = 0;

    // Expected address phases of a run, straight from the pattern rules
    task automatic push_run(input logic [31:0] base, input int npass);
      for (int p = 0; p < npass; p++)
        for (int ph = 0; ph < 2; ph++)
          for (int i = 0; i < WC; i++) begin
            beat_t b;
            logic [31:0] v;
            b.addr = base + 32'(4 * i);
            b.wr   = (ph == 0);
            b.tr   = (BM != 0 && (i % 4) != 0) ? 2'b11 : 2'b10;
            b.hb   = (BM != 0) ? 3'b011 : 3'b000;
            v      = (PT != 0) ? (b.addr ^ 32'hA5A5_A5A5) : b.addr;
            b.data = (p % 2 == 1) ? ~v : v;
            exp_q.push_back(b);
          end
    endtask

    task automatic check_rst();
      check($sformatf("reset_bus_u%0d", g), {htrans, haddr, hwdata, hwrite, hsel, hburst, hsize},
            {2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 3'b010});
      check($sformatf("reset_stat_u%0d", g), {errc, chkc, ferr, s_w, s_c, s_s, s_f},
            {32'h0, 8'h0, 32'h0, 4'b0000});
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any edge
    task automatic pulse_reset();
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check_rst();
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
    endtask

    task automatic wait_chk(input logic [7:0] k);
      int c = 0;
      while (chkc != k && c < 1500) begin @(negedge clk); c++; end
      check($sformatf("chkcount_%0d_u%0d", k, g), chkc, k);
    endtask

    task automatic start_idle(input logic [31:0] sa, input int npass);
      saddr = sa;
      push_run(sa & 32'hFFFF_FFFC, npass);
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      check($sformatf("first_nonseq_u%0d", g), {htrans, haddr}, {2'b10, sa & 32'hFFFF_FFFC});
    endtask

    // Slave + monitor: decides HREADY/HRDATA/HRESP for the coming edge and
    // scores every beat the DUT gets accepted
    beat_t       dp;
    logic [31:0] dp_addr, rd;
    bit          dp_v = 1'b0, stalled = 1'b0;
    int          stall_left = 0;
    logic [69:0] snap = '0;
    always @(negedge clk) begin
      if (!rst_n) begin
        dp_v = 1'b0; stalled = 1'b0; stall_left = 0; hready = 1'b1; hresp = 1'b0;
      end else begin
        if (stalled)
          check($sformatf("hold_u%0d", g), {haddr, htrans, hburst, hwrite, hwdata}, snap);
        hresp = 1'b0;
        if (dp_v && stall_left > 0) begin
          hready = 1'b0;
          stall_left--;
        end else begin
          hready = 1'b1;
          if (dp_v) begin
            if (dp.wr) begin
              check($sformatf("wdata_u%0d_%h", g, dp_addr), hwdata, dp.data);
              mem[dp_addr] = hwdata;
              if (resp_armed && dp_addr == resp_addr) begin hresp = 1'b1; resp_armed = 1'b0; end
            end else begin
              rd = mem.exists(dp_addr) ? mem[dp_addr] : 32'hDEAD_BEEF;
              if (flip_en && dp_addr == flip_addr) rd[0] = ~rd[0];
              hrdata = rd;
            end
          end
          dp_v = 1'b0;
          if (htrans[1]) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_beat_u%0d: got beat at %h, required none", g, haddr);
            end else begin
              dp = exp_q.pop_front();
              check($sformatf("beat_u%0d_%h", g, dp.addr), {haddr, hwrite, htrans, hburst, hsize, hsel},
                    {dp.addr, dp.wr, dp.tr, dp.hb, 3'b010, 1'b1});
              dp_addr = haddr;
              dp_v    = 1'b1;
              nacc++;
              if ($urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 3);
            end
          end
        end
        stalled = !hready;
        snap    = {haddr, htrans, hburst, hwrite, hwdata};
      end
    end

    // Stimulus per instance
    initial begin
      logic [31:0] sa;
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_rst();
      #2 rst_n = 1'b1;
      if (g == 0) begin
        // Run forever, clean memory: three passes counted, then reset mid pass 4
        start_idle(32'h1, 4);
        wait_chk(8'd1); wait_chk(8'd2); wait_chk(8'd3);
        check("forever_status_u0", {errc, s_s, s_f}, {32'h0, 1'b1, 1'b0});
        start = 1'b0;
        pulse_reset();
        // Address wrap with an ERROR response on one write beat
        resp_addr = 32'hFFFF_FFFC; resp_armed = 1'b1;
        start_idle(32'hFFFF_FFF4, 3);
        wait_chk(8'd1);
        check("resp_err_u0", {errc, ferr}, {32'd1, 32'hFFFF_FFFC});
        wait_chk(8'd2);
        check("resp_status_u0", {errc, s_f, s_s}, {32'd1, 1'b1, 1'b0});
        start = 1'b0;
        pulse_reset();
      end else begin
        // Two INCR4 passes with bit 0 of one word corrupted on every read
        sa = ($urandom & 32'h000F_FF00) | 32'h1;
        flip_addr = (sa & 32'hFFFF_FFFC) + 32'h10; flip_en = 1'b1;
        start_idle(sa, 2);
        wait_chk(8'd1);
        check("flip_pass1_u1", {errc, ferr, s_f, s_s}, {32'd1, flip_addr, 1'b1, 1'b0});
        wait_chk(8'd2);
        repeat (5) @(negedge clk);
        check("flip_done_u1", {errc, ferr, s_f, s_s, s_w, s_c, htrans, hsel},
              {32'd2, flip_addr, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        check("flip_drained_u1", exp_q.size(), 0);
        // New run from DONE needs a START rising edge and clears the counters
        flip_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        sa = $urandom & 32'h00FF_FFF0;
        saddr = sa;
        push_run(sa, 2);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_u1", {htrans, haddr, errc, chkc, s_f}, {2'b10, sa, 32'h0, 8'h0, 1'b0});
        wait_chk(8'd1); wait_chk(8'd2);
        @(negedge clk);
        check("clean_done_u1", {errc, s_s, s_f, s_w, s_c}, {32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("clean_drained_u1", exp_q.size(), 0);
        // Reset during write beat 3, START held high so the run restarts at once
        start = 1'b0;
        @(negedge clk);
        sa = $urandom & 32'h00FF_FFF0;
        saddr = sa;
        push_run(sa, 2);
        nacc = 0;
        start = 1'b1;
        for (int c = 0; c < 200 && nacc < 3; c++) @(negedge clk);
        check("beat3_reached_u1", nacc >= 3, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check_rst();
        exp_q.delete();
        push_run(sa, 2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_first_u1", {htrans, haddr, chkc}, {2'b10, sa, 8'h0});
        wait_chk(8'd1); wait_chk(8'd2);
        @(negedge clk);
        check("after_rst_done_u1", {errc, s_s, s_f}, {32'h0, 1'b1, 1'b0});
        check("after_rst_drained_u1", exp_q.size(), 0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int c = 0;
    while (!(u[0].fin && u[1].fin) && c < 20000) begin @(negedge clk); c++; end
    if (!(u[0].fin && u[1].fin)) begin
      n_chk++;
      $display("FAIL run_timeout: got unfinished after %0d cycles, required finished", c);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
